// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: control-bundle bit positions,
// primary opcodes and default datapath widths.
package mips_pkg;

  // Default datapath widths
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 10;
  localparam int CNT_W      = 16;

  // Bit positions inside the decoder control bundle
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_JUMP     = 9;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: an instruction in EX that loads into
// a register the ID instruction is about to read. Shared with the IF/ID stage.
module load_use_detect #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_alu_src,
  input  logic                  id_mem_write,
  output logic                  hazard
);

  logic rt_used;
  logic rs_match;
  logic rt_match;

  // rt is a source for R-type/branch (AluSrc=0) and as store data (MemWrite=1)
  assign rt_used  = !id_alu_src || id_mem_write;
  assign rs_match = (ex_rt == id_rs);
  assign rt_match = (ex_rt == id_rt) && rt_used;

  // $zero is never a real dependency, so rt=0 cannot trigger a stall
  assign hazard = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid &&
                  (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and freeze.
// Optional macro ID_EX_PERF_CNT_EN adds saturating bubble/flush counters.
module id_ex_stage #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CTRL_W     = mips_pkg::CTRL_W,
  parameter int CNT_W      = mips_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic                  id_valid_i,
  input  logic [DATA_W-1:0]     rd1_i,
  input  logic [DATA_W-1:0]     rd2_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [DATA_W-1:0]     pc4_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [DATA_W-1:0]     pc4_o,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  stall_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  logic              hazard;
  logic [CTRL_W-1:0] ctrl_next;
  logic              valid_next;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_valid     (valid_o),
    .ex_mem_read  (ctrl_o[mips_pkg::CTRL_MEMREAD]),
    .ex_rt        (rt_o),
    .id_valid     (id_valid_i),
    .id_rs        (rs_i),
    .id_rt        (rt_i),
    .id_alu_src   (ctrl_i[mips_pkg::CTRL_ALUSRC]),
    .id_mem_write (ctrl_i[mips_pkg::CTRL_MEMWRITE]),
    .hazard       (hazard)
  );

  // A dead (flushed) or frozen ID instruction must not hold the front end
  assign stall_o = hazard && !flush_i && !hold_i;

  // Next control/valid for the EX register, flush > hold > bubble > load
  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so
    // no path through the block leaves it unassigned and infers a latch.
    ctrl_next  = ctrl_o;
    valid_next = valid_o;
    if (flush_i) begin
      ctrl_next  = '0;
      valid_next = 1'b0;
    end else if (hold_i) begin
      ctrl_next  = ctrl_o;
      valid_next = valid_o;
    end else if (hazard) begin
      ctrl_next  = '0;
      valid_next = 1'b0;
    end else begin
      // The select keeps undriven decoder bits of empty slots out of EX
      ctrl_next  = id_valid_i ? ctrl_i : '0;
      valid_next = id_valid_i;
    end
  end

  // Control and valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      ctrl_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      ctrl_o  <= ctrl_next;
      valid_o <= valid_next;
    end
  end

  // Operand and specifier registers, frozen only by hold_i
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data fields are reset too; they are visible ports and rt_o
    // feeds the hazard compare, so they must not start out unknown.
    if (!rst_n) begin
      rd1_o <= '0;
      rd2_o <= '0;
      imm_o <= '0;
      pc4_o <= '0;
      rs_o  <= '0;
      rt_o  <= '0;
      rd_o  <= '0;
    end else if (flush_i || !hold_i) begin
      rd1_o <= rd1_i;
      rd2_o <= rd2_i;
      imm_o <= imm_i;
      pc4_o <= pc4_i;
      rs_o  <= rs_i;
      rt_o  <= rt_i;
      rd_o  <= rd_i;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_evt;
  logic flush_evt;

  assign bubble_evt = hazard && !flush_i && !hold_i;
  assign flush_evt  = flush_i && id_valid_i && !hold_i;

  // Saturating event counters, paused while EX is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (bubble_evt && (bubble_cnt_o != '1)) begin
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
      if (flush_evt && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
